// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte-write and status bundle between bus decode and the UART transmitter
//   master drives wr / wr_data / ovf_clr and observes status
//   slave (the transmitter) drives txd, busy, full, empty, count, overflow
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 2
);
  logic                  wr;
  logic [7:0]            wr_data;
  logic                  ovf_clr;
  logic                  txd;
  logic                  busy;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  modport master (output wr, wr_data, ovf_clr, input txd, busy, full, empty, count, overflow);
  modport slave  (input wr, wr_data, ovf_clr, output txd, busy, full, empty, count, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter fed by memory-mapped byte writes
//   clk, rst : clock and asynchronous active-high reset
//   bus      : wr/wr_data/ovf_clr in; txd, busy, full, empty, count, overflow out
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH_LOG2   = 2
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  ovf_q, ovf_d;
  logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic [7:0]            mem_q [DEPTH];
  logic                  full, empty, tick, pop, push;
  // count never exceeds DEPTH, so its top bit alone marks full
  assign full  = cnt_q[DEPTH_LOG2];
  assign empty = cnt_q == '0;
  assign tick  = baud_q == BW'(CLKS_PER_BIT - 1);
  // the head leaves the FIFO on IDLE exit or on a STOP boundary chaining into the next frame
  assign pop   = !empty && (state_q == IDLE || (state_q == STOP && tick));
  // a pop in the same cycle frees the slot a full FIFO needs
  assign push  = bus.wr && (!full || pop);
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = pop ? mem_q[rp_q] : shift_q;
    baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
    wp_d    = push ? wp_q + 1'b1 : wp_q;
    rp_d    = pop ? rp_q + 1'b1 : rp_q;
    cnt_d   = cnt_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
    ovf_d   = (bus.wr && full && !pop) || (ovf_q && !bus.ovf_clr);
    case (state_q)
      IDLE:  state_d = pop ? START : IDLE;
      START: begin
        state_d = tick ? DATA : START;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP:  state_d = tick ? (pop ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
    // txd is registered from the next state so the line changes exactly on the edge
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
    end
  end
  // storage needs no reset: only slots between the pointers are ever read
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus.wr_data;
  end
  assign bus.txd      = txd_q;
  assign bus.busy     = state_q != IDLE;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = cnt_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed, table-driven bench for uart_tx_fifo with a serial-line receiver
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  localparam int DL  = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [7:0]  rx_q [$];
  int          gap_q [$];
  logic        mon_on = 1'b0;
  int          mon_cnt = 0;
  int          idle_run = 0;
  int          frame_err = 0;
  logic [7:0]  mon_sh = '0;
  logic [DL:0] max_cnt = '0;
  logic [7:0]  want [9];
  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    logic [2:0] cnt;
    logic       full;
    logic       ovf;
  } vec_t;
  vec_t tbl [10];
  always @(negedge clk) begin
    if (bus.count > max_cnt) max_cnt <= bus.count;
  end
  // independent 8N1 receiver sampling mid-bit; records bytes and idle cycles before each frame
  always @(negedge clk) begin
    if (rst) begin
      mon_on   <= 1'b0;
      mon_cnt  <= 0;
      idle_run <= 0;
    end else if (!mon_on) begin
      if (!bus.txd) begin
        mon_on  <= 1'b1;
        mon_cnt <= 1;
        gap_q.push_back(idle_run);
      end else idle_run <= idle_run + 1;
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt == CPB / 2 && bus.txd) frame_err <= frame_err + 1;
      if (mon_cnt > CPB && mon_cnt < 9 * CPB && mon_cnt % CPB == CPB / 2) mon_sh <= {bus.txd, mon_sh[7:1]};
      if (mon_cnt == 9 * CPB + CPB / 2 && !bus.txd) frame_err <= frame_err + 1;
      if (mon_cnt == 10 * CPB - 1) begin
        rx_q.push_back(mon_sh);
        mon_on   <= 1'b0;
        idle_run <= 0;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic put(input logic w, input logic [7:0] d, input logic c);
    bus.wr = w;
    bus.wr_data = d;
    bus.ovf_clr = c;
  endtask
  task automatic drain(input string name);
    int n = 0;
    while ((!bus.empty || bus.busy) && n < 3000) begin
      step();
      n++;
    end
    step(2);
    chk(name, 32'(bus.empty && !bus.busy), 1);
  endtask
  task automatic chk_rx(input string name, input int base, input int n, input bit gapless);
    chk($sformatf("%s rx count", name), rx_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < rx_q.size()) chk($sformatf("%s byte%0d", name, i), 32'(rx_q[base + i]), 32'(want[i]));
      if (gapless && i > 0 && base + i < gap_q.size()) chk($sformatf("%s gap%0d", name, i), gap_q[base + i], 0);
    end
  endtask
  initial begin
    int base;
    int low;
    logic [9:0] fr;
    put(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    step(2);
    chk("reset txd", 32'(bus.txd), 1);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset full", 32'(bus.full), 0);
    chk("reset empty", 32'(bus.empty), 1);
    chk("reset count", 32'(bus.count), 0);
    chk("reset overflow", 32'(bus.overflow), 0);
    rst = 1'b0;
    step(2);
    // single byte 'b': start, 0,1,0,0,0,1,1,0, stop, CPB cycles each
    fr = {1'b1, 8'h62, 1'b0};
    put(1'b1, 8'h62, 1'b0);
    step();
    put(1'b0, 8'h00, 1'b0);
    chk("t1 txd after write", 32'(bus.txd), 1);
    chk("t1 count after write", 32'(bus.count), 1);
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < CPB; c++) begin
        step();
        chk($sformatf("t1 txd bit%0d cyc%0d", b, c), 32'(bus.txd), 32'(fr[b]));
        chk($sformatf("t1 busy bit%0d cyc%0d", b, c), 32'(bus.busy), 1);
      end
    step();
    chk("t1 busy end", 32'(bus.busy), 0);
    chk("t1 empty end", 32'(bus.empty), 1);
    chk("t1 txd end", 32'(bus.txd), 1);
    // burst fill, dropped write, overflow clear and set-wins
    tbl[0] = '{1'b1, 8'h41, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h42, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h43, 1'b0, 3'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 3'd3, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h45, 1'b0, 3'd4, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h46, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 8'h47, 1'b1, 3'd4, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0};
    base = rx_q.size();
    for (int i = 0; i < 10; i++) begin
      put(tbl[i].wr, tbl[i].d, tbl[i].clr);
      step();
      chk($sformatf("t2 row%0d count", i), 32'(bus.count), 32'(tbl[i].cnt));
      chk($sformatf("t2 row%0d full", i), 32'(bus.full), 32'(tbl[i].full));
      chk($sformatf("t2 row%0d overflow", i), 32'(bus.overflow), 32'(tbl[i].ovf));
    end
    put(1'b0, 8'h00, 1'b0);
    drain("t2 drain");
    want[0] = 8'h41; want[1] = 8'h42; want[2] = 8'h43; want[3] = 8'h44; want[4] = 8'h45;
    chk_rx("t2", base, 5, 1'b1);
    // push while full on the STOP boundary that pops
    base = rx_q.size();
    put(1'b1, 8'h61, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 8'h62 + 8'(i), 1'b0);
      step();
    end
    put(1'b0, 8'h00, 1'b0);
    step(36);
    chk("t3 count before", 32'(bus.count), 4);
    chk("t3 stop txd", 32'(bus.txd), 1);
    put(1'b1, 8'h55, 1'b0);
    step();
    put(1'b0, 8'h00, 1'b0);
    chk("t3 count after", 32'(bus.count), 4);
    chk("t3 overflow", 32'(bus.overflow), 0);
    chk("t3 next start txd", 32'(bus.txd), 0);
    drain("t3 drain");
    want[0] = 8'h61; want[1] = 8'h62; want[2] = 8'h63; want[3] = 8'h64; want[4] = 8'h65; want[5] = 8'h55;
    chk_rx("t3", base, 6, 1'b1);
    // asynchronous reset during data bit 3 with two bytes queued
    base = rx_q.size();
    put(1'b1, 8'h62, 1'b0);
    step();
    put(1'b1, 8'h11, 1'b0);
    step();
    put(1'b1, 8'h22, 1'b0);
    step();
    put(1'b0, 8'h00, 1'b0);
    step(16);
    chk("t4 txd bit3", 32'(bus.txd), 0);
    chk("t4 count queued", 32'(bus.count), 2);
    #2 rst = 1'b1;
    #1;
    chk("t4 async txd", 32'(bus.txd), 1);
    chk("t4 async count", 32'(bus.count), 0);
    chk("t4 async busy", 32'(bus.busy), 0);
    chk("t4 async overflow", 32'(bus.overflow), 0);
    chk("t4 async empty", 32'(bus.empty), 1);
    step(2);
    rst = 1'b0;
    low = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!bus.txd) low++;
    end
    chk("t4 line stays high", low, 0);
    chk("t4 no frame", rx_q.size() - base, 0);
    chk("t4 busy after", 32'(bus.busy), 0);
    // pointer wrap: 9 bytes in groups of 3
    base = rx_q.size();
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 3; i++) begin
        put(1'b1, 8'hA0 + 8'(g * 3 + i), 1'b0);
        step();
      end
      put(1'b0, 8'h00, 1'b0);
      drain($sformatf("t5 drain%0d", g));
    end
    for (int i = 0; i < 9; i++) want[i] = 8'hA0 + 8'(i);
    chk_rx("t5", base, 9, 1'b0);
    chk("max count le depth", 32'(max_cnt <= 3'd4), 1);
    chk("framing errors", frame_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Memory-mapped UART transmitter that consumes the core's byte writes to the UART TX address (1028) and serialises them onto a single TX line.
- Downstream of the bus decode: the top level drives wr = mem && mem_write && uart_tx_select and wr_data = data_out[7:0].
- A small FIFO absorbs store bursts, so the core never stalls on TX.
- Status outputs are exposed for a readable status word and for the bench.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit. Legal values are 2 or more.
- DEPTH_LOG2, 2, log2 of FIFO depth. Default depth is 4 entries.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- wr  input  1  write strobe, one byte per cycle when high
- wr_data  input  8  byte to transmit
- ovf_clr  input  1  clears the sticky overflow flag
- txd  output  1  serial line; idles high
- busy  output  1  high while a frame is on the line (state != IDLE)
- full  output  1  FIFO holds 2^DEPTH_LOG2 entries
- empty  output  1  FIFO holds 0 entries
- count  output  DEPTH_LOG2+1  current FIFO occupancy
- overflow  output  1  sticky flag: a write was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, held or pulsed):
  - txd=1, busy=0, full=0, empty=1, count=0, overflow=0.
  - FSM goes to IDLE; pointers, bit counter and baud counter go to 0.
  - Reset mid-frame aborts the frame immediately and drives txd high. Partial frames are not resumed.
- FIFO:
  - Circular buffer with read/write pointers of DEPTH_LOG2 bits that wrap modulo depth.
  - count tracks occupancy.
- Write acceptance:
  - A write is accepted when wr=1 and either (not full) or (a pop occurs in the same cycle).
  - A write with wr=1 while full and no pop is dropped and sets overflow=1 at that edge.
  - Simultaneous push and pop leaves count unchanged.
- Overflow flag:
  - overflow stays set until ovf_clr=1.
  - If ovf_clr and a dropped write occur in the same cycle, set wins.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - A bit boundary is the cycle where the counter equals CLKS_PER_BIT-1. The counter then returns to 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If not empty, pop the head into the shift register and go to START at that edge.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd = shift[0], LSB first. At each bit boundary, shift right and increment the index. After bit 7's boundary, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At the boundary:
    - if the FIFO is not empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Latency:
  - A write accepted at edge N into an empty FIFO in IDLE makes the FIFO non-empty after N.
  - Pop and IDLE->START happen at edge N+1; txd falls after edge N+1.
  - A frame is exactly 10*CLKS_PER_BIT cycles.
- Output registration: txd is registered; it changes only on clk edges or on reset assertion.
- Writes are ignored by the FSM path: only the FIFO is affected, and the shift register is never overwritten mid-frame.
- Throughput: back-to-back frames have no gap. Sustained rate is one byte per 10*CLKS_PER_BIT cycles.

Test Plan:
- Single byte, CLKS_PER_BIT=4: write 0x62 ('b') once.
  - txd must be 1 for the cycle after the write.
  - Then, 4 cycles each: 0 (start), then 0,1,0,0,0,1,1,0 (data LSB first), then 1 (stop).
  - Then IDLE with busy=0, empty=1. The frame is 40 cycles total.
- Burst fill, DEPTH_LOG2=2: write 0x41,0x42,0x43,0x44,0x45 on consecutive cycles starting from IDLE.
  - 0x41 pops the cycle after its write, so all 5 are accepted. count peaks at 4 and full=1.
  - A sixth write (0x46) while full, before the first frame ends, is dropped and overflow=1.
  - 0x41..0x45 are transmitted in order with no idle gap between frames.
- Overflow clear: with overflow=1, pulse ovf_clr → overflow=0 next cycle. ovf_clr together with a dropped write → overflow remains 1.
- Push while full with simultaneous pop: FIFO full, write 0x55 on the STOP-boundary cycle.
  - The write is accepted, count stays 4, overflow stays 0.
  - 0x55 is sent last.
- Reset mid-frame: assert rst during DATA bit 3 of 0x62 with 2 bytes queued.
  - txd=1, count=0, busy=0, overflow=0 immediately, without waiting for a clock edge.
  - After release, the line stays high until a new write.
- Pointer wrap: write and transmit 9 bytes in groups of 3 with DEPTH_LOG2=2 → all 9 bytes appear on txd in order, and count never exceeds 4.
